// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-256 inverse cipher.
package aes_pkg;

    localparam int NR = 14;
    localparam logic [3:0] LAST_KEY_IDX = 4'(NR);

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    // Byte n is row n%4, column n/4; byte 0 occupies bits [127:120].
    function automatic int byte_idx(input int row, input int col);
        return row + 4 * col;
    endfunction

    function automatic logic [7:0] get_byte(input aes_state_t s, input int n);
        return s[127 - 8 * n -: 8];
    endfunction

    function automatic aes_state_t set_byte(input aes_state_t s, input int n, input logic [7:0] b);
        aes_state_t o;
        o = s;
        o[127 - 8 * n -: 8] = b;
        return o;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Block-in / block-out handshake plus the round-key lookup to the external key store.
// A transfer happens on a rising edge where valid and ready are both 1; valid, once raised, holds with its data until that edge.
interface aes_inv_cipher_if;
    logic         inValid;
    logic         inReady;
    logic [127:0] cipherText;
    logic [3:0]   roundKeyIdx;
    logic [127:0] roundKey;
    logic         outValid;
    logic         outReady;
    logic [127:0] plainText;
    logic         busy;

    modport master (
        output inValid, cipherText, roundKey, outReady,
        input  inReady, roundKeyIdx, outValid, plainText, busy
    );

    modport slave (
        input  inValid, cipherText, roundKey, outReady,
        output inReady, roundKeyIdx, outValid, plainText, busy
    );
endinterface

// File: rtl/inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion (x^254).
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    logic [7:0] aff;
    logic [7:0] pw;
    logic [7:0] acc;

    assign aff = rotl8(in_byte, 1) ^ rotl8(in_byte, 3) ^ rotl8(in_byte, 6) ^ 8'h05;

    // Multiply a^2 * a^4 * ... * a^128 = a^254; zero maps to zero for free.
    always_comb begin
        pw  = aff;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        out_byte = acc;
    end
endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-256 inverse cipher, one round per clock, round keys fetched by index.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    aes_inv_cipher_if.slave  bus,
    output fsm_state_e       dbg_state
);
    fsm_state_e fsm_q, fsm_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rk_idx_q, rk_idx_d;
    aes_state_t state_q, state_d;
    aes_state_t pt_q, pt_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;

    logic       in_ready;
    logic       accept;
    aes_state_t isr, isb, ark, imc;
    logic [7:0] sb_in  [16];
    logic [7:0] sb_out [16];

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o = set_byte(o, byte_idx(r, c), get_byte(s, byte_idx(r, (c - r + 4) % 4)));
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, byte_idx(0, c));
            a1 = get_byte(s, byte_idx(1, c));
            a2 = get_byte(s, byte_idx(2, c));
            a3 = get_byte(s, byte_idx(3, c));
            o = set_byte(o, byte_idx(0, c), mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3));
            o = set_byte(o, byte_idx(1, c), mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3));
            o = set_byte(o, byte_idx(2, c), mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3));
            o = set_byte(o, byte_idx(3, c), mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3));
        end
        return o;
    endfunction

    assign isr = inv_shift_rows(state_q);

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        assign sb_in[g] = get_byte(isr, g);
        inv_sbox u_inv_sbox (
            .in_byte  (sb_in[g]),
            .out_byte (sb_out[g])
        );
    end

    always_comb begin
        isb = '0;
        for (int n = 0; n < 16; n++) isb = set_byte(isb, n, sb_out[n]);
    end

    assign ark = isb ^ bus.roundKey;
    assign imc = inv_mix_columns(ark);

    // A finished block can be handed off and the next one taken on the same edge.
    assign in_ready = (fsm_q == ST_IDLE) || (out_valid_q && bus.outReady);
    assign accept   = bus.inValid && in_ready;

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        rk_idx_d    = rk_idx_q;
        state_d     = state_q;
        pt_d        = pt_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (fsm_q)
            ST_IDLE: ;
            ST_ROUND: begin
                state_d = imc;
                if (cnt_q == 4'd1) begin
                    fsm_d    = ST_FINAL;
                    cnt_d    = 4'd0;
                    rk_idx_d = 4'd0;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    rk_idx_d = cnt_q - 4'd1;
                end
            end
            ST_FINAL: begin
                state_d  = ark;
                fsm_d    = ST_DONE;
                rk_idx_d = LAST_KEY_IDX;
                busy_d   = 1'b0;
            end
            ST_DONE: begin
                // First DONE cycle moves the result into the output register.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    pt_d        = state_q;
                end else if (bus.outReady) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d  = bus.cipherText ^ bus.roundKey;
            cnt_d    = LAST_KEY_IDX - 4'd1;
            rk_idx_d = LAST_KEY_IDX - 4'd1;
            fsm_d    = ST_ROUND;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= 4'd0;
            rk_idx_q    <= LAST_KEY_IDX;
            state_q     <= '0;
            pt_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            rk_idx_q    <= rk_idx_d;
            state_q     <= state_d;
            pt_q        <= pt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.inReady     = in_ready;
    assign bus.roundKeyIdx = rk_idx_q;
    assign bus.outValid    = out_valid_q;
    assign bus.plainText   = pt_q;
    assign bus.busy        = busy_q;
    assign dbg_state       = fsm_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: blocks are made by a forward AES-256 model, so the expected output is the random plaintext.
module tb_aes_inv_cipher;
    import aes_pkg::*;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic       clk = 1'b0;
    logic       rst;
    fsm_state_e dbg_state;
    aes_inv_cipher_if bus ();

    aes_inv_cipher dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- key store and reference model ----------------
    logic [7:0]   sbox_t [256];
    logic [127:0] rk [16];
    always_comb bus.roundKey = rk[bus.roundKeyIdx];

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] tb_rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ tb_rotl(inv, 1) ^ tb_rotl(inv, 2) ^ tb_rotl(inv, 3) ^ tb_rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                rc = 8'h01 << (i / 8 - 1);
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        rk[15] = '0;
    endtask

    function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k, input bit mix);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] o;
        for (int n = 0; n < 16; n++) a[n] = sbox_t[s[127 - 8 * n -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[r + 4 * c] = a[r + 4 * ((c + r) % 4)];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c]   = tb_gmul(b[4*c], 8'h02) ^ tb_gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ tb_gmul(b[4*c+1], 8'h02) ^ tb_gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ tb_gmul(b[4*c+2], 8'h02) ^ tb_gmul(b[4*c+3], 8'h03);
                a[4*c+3] = tb_gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ tb_gmul(b[4*c+3], 8'h02);
            end
            for (int n = 0; n < 16; n++) b[n] = a[n];
        end
        for (int n = 0; n < 16; n++) o[127 - 8 * n -: 8] = b[n];
        return o ^ k;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] s;
        s = p ^ rk[0];
        for (int r = 1; r < 14; r++) s = fwd_round(s, rk[r], 1'b1);
        return fwd_round(s, rk[14], 1'b0);
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic score_out(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, bus.plainText, 128'hx);
        else check_eq(tag, bus.plainText, exp_q.pop_front());
    endtask

    // ---------------- drivers ----------------
    task automatic send_block(input logic [127:0] ct, input bit hold, output int acc);
        int i;
        acc = -1;
        for (i = 0; i < 40 && !bus.inReady; i++) @(negedge clk);
        if (!bus.inReady) begin
            check_eq("in_ready_timeout", 128'(bus.inReady), 128'd1);
        end else begin
            bus.inValid    = 1'b1;
            bus.cipherText = ct;
            @(negedge clk);
            acc = cyc;
            if (!hold) bus.inValid = 1'b0;
        end
    endtask

    task automatic wait_out(input string tag, output int seen);
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.outValid) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        if (seen < 0) check_eq({tag, "_timeout"}, 128'(bus.outValid), 128'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc2, t1, t2, seen;
        logic [255:0] key;
        logic [127:0] pt;

        rst            = 1'b1;
        bus.inValid    = 1'b0;
        bus.cipherText = '0;
        bus.outReady   = 1'b1;
        build_sbox();
        load_key(C3_KEY);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_out_valid", 128'(bus.outValid), 128'd0);
        check_eq("rst_plain", bus.plainText, 128'd0);
        check_eq("rst_busy", 128'(bus.busy), 128'd0);
        check_eq("rst_in_ready", 128'(bus.inReady), 128'd1);
        check_eq("rst_rk_idx", 128'(bus.roundKeyIdx), 128'd14);
        check_eq("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        check_eq("model_c3", encrypt(C3_PT), C3_CT);

        // FIPS-197 C.3 with key index trace and latency
        exp_q.push_back(C3_PT);
        send_block(C3_CT, 1'b0, acc);
        for (int j = 0; j < 14; j++) begin
            check_eq($sformatf("c3_rk_idx_%0d", j), 128'(bus.roundKeyIdx), 128'(13 - j));
            if (j == 0) check_eq("c3_busy", 128'(bus.busy), 128'd1);
            @(negedge clk);
        end
        check_eq("c3_idx_done", 128'(bus.roundKeyIdx), 128'd14);
        wait_out("c3", seen);
        check_eq("c3_latency", 128'(seen - acc), 128'd15);
        check_eq("c3_busy_done", 128'(bus.busy), 128'd0);
        score_out("c3_pt");
        @(negedge clk);
        check_eq("c3_drop_valid", 128'(bus.outValid), 128'd0);
        check_eq("c3_idle", 128'(dbg_state), 128'(ST_IDLE));

        // output stall: result must hold while outReady is low
        bus.outReady = 1'b0;
        exp_q.push_back(C3_PT);
        send_block(C3_CT, 1'b0, acc);
        wait_out("stall", seen);
        check_eq("stall_latency", 128'(seen - acc), 128'd15);
        score_out("stall_pt");
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_eq("stall_hold_pt", bus.plainText, C3_PT);
            check_eq("stall_hold_valid", 128'(bus.outValid), 128'd1);
            check_eq("stall_in_ready", 128'(bus.inReady), 128'd0);
            check_eq("stall_busy", 128'(bus.busy), 128'd0);
        end
        bus.outReady = 1'b1;
        @(negedge clk);
        check_eq("stall_release", 128'(bus.outValid), 128'd0);

        // back-to-back with inValid held high
        exp_q.push_back(C3_PT);
        exp_q.push_back(C3_PT);
        send_block(C3_CT, 1'b1, acc);
        wait_out("b2b_first", t1);
        check_eq("b2b_latency", 128'(t1 - acc), 128'd15);
        check_eq("b2b_in_ready", 128'(bus.inReady), 128'd1);
        score_out("b2b_pt1");
        @(negedge clk);
        acc2 = cyc;
        bus.inValid = 1'b0;
        check_eq("b2b_second_accept", 128'(dbg_state), 128'(ST_ROUND));
        check_eq("b2b_accept_gap", 128'(acc2 - t1), 128'd1);
        wait_out("b2b_second", t2);
        check_eq("b2b_period", 128'(t2 - t1), 128'd16);
        score_out("b2b_pt2");
        @(negedge clk);
        check_eq("b2b_drain", 128'(bus.outValid), 128'd0);

        // reset in the middle of a block
        send_block(C3_CT, 1'b0, acc);
        for (int i = 0; i < 20 && bus.roundKeyIdx != 4'd7; i++) @(negedge clk);
        check_eq("abort_reach_idx7", 128'(bus.roundKeyIdx), 128'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_out_valid", 128'(bus.outValid), 128'd0);
        check_eq("abort_plain", bus.plainText, 128'd0);
        check_eq("abort_in_ready", 128'(bus.inReady), 128'd1);
        check_eq("abort_busy", 128'(bus.busy), 128'd0);
        exp_q.push_back(C3_PT);
        send_block(C3_CT, 1'b0, acc);
        wait_out("abort_next", seen);
        check_eq("abort_next_latency", 128'(seen - acc), 128'd15);
        score_out("abort_next_pt");
        @(negedge clk);

        // inValid pulses during the rounds must be ignored
        exp_q.push_back(C3_PT);
        send_block(C3_CT, 1'b0, acc);
        for (int j = 0; j < 13; j++) begin
            bus.inValid    = (j % 3 == 0);
            bus.cipherText = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (j % 6 == 0) check_eq("ignore_in_ready", 128'(bus.inReady), 128'd0);
            @(negedge clk);
        end
        bus.inValid = 1'b0;
        wait_out("ignore", seen);
        check_eq("ignore_latency", 128'(seen - acc), 128'd15);
        score_out("ignore_pt");
        @(negedge clk);

        // random keys and blocks against the forward model
        for (int k = 0; k < 1000; k++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(key);
            exp_q.push_back(pt);
            bus.outReady = ($urandom_range(0, 3) != 0);
            send_block(encrypt(pt), 1'b0, acc);
            wait_out("rand", seen);
            score_out("rand_pt");
            if (!bus.outReady) repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.outReady = 1'b1;
            @(negedge clk);
        end
        check_eq("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
